// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: target FSM states and the default camera address.
// The SCCB master uses the same address constant.
package sccb_pkg;

  localparam logic [7:0] SCCB_CAM_ADDR = 8'h42;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_ACK_DEV   = 4'd2,
    ST_REG       = 4'd3,
    ST_ACK_REG   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_ACK_DATA  = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RD_NA     = 4'd8,
    ST_WAIT_STOP = 4'd9
  } sccb_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizer for one open-drain SCCB line plus edge detection.
// The edge detector compares the last two synchronized samples.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Flops reset to 1 so an idle (pulled-up) bus produces no edge after reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_line};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/sccb_target.sv
// SCCB target with a 256x8 register file and a persistent register pointer.
// wr_valid is a one-clock strobe (no ready): wr_addr/wr_data are valid in that cycle.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = SCCB_CAM_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SIOC,
  input  logic        SIOD,
  output logic        SIOD_oe,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output sccb_state_t dbg_state
);

  localparam logic [7:0] RD_ADDR = DEV_ADDR | 8'h01;

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte_next;

  sccb_state_t r_state;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_ptr;
  logic        r_rd;
  logic        r_oe;
  logic        r_wr_valid;
  logic [7:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [7:0]  r_regs [256];

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .i_clk(clk), .i_reset(reset), .i_line(SIOC),
    .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .i_clk(clk), .i_reset(reset), .i_line(SIOD),
    .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start     = w_sda_fall & w_scl_lvl;
  assign w_stop      = w_sda_rise & w_scl_lvl;
  assign w_byte_next = {r_shift[6:0], w_sda_lvl};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_rd       <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      for (int i = 0; i < 256; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start) begin
        r_state   <= ST_DEV;
        r_bit_cnt <= 4'd0;
        r_shift   <= 8'h00;
        r_oe      <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 4'd0;
        r_oe      <= 1'b0;
      end else begin
        case (r_state)
          ST_DEV, ST_REG, ST_WDATA: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_shift   <= w_byte_next;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_state == ST_WDATA && r_bit_cnt == 4'd7) begin
                r_regs[r_ptr] <= w_byte_next;
                r_wr_valid    <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte_next;
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              case (r_state)
                ST_DEV: begin
                  if (r_shift == DEV_ADDR || r_shift == RD_ADDR) begin
                    r_state <= ST_ACK_DEV;
                    r_rd    <= (r_shift == RD_ADDR);
                    r_oe    <= 1'b1;
                  end else begin
                    r_state <= ST_WAIT_STOP;
                  end
                end
                ST_REG: begin
                  r_ptr   <= r_shift;
                  r_state <= ST_ACK_REG;
                  r_oe    <= 1'b1;
                end
                default: begin
                  r_state <= ST_ACK_DATA;
                  r_oe    <= 1'b1;
                end
              endcase
            end
          end
          ST_ACK_DEV: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rd) begin
                // First read bit goes out on the same falling edge that ends the ACK.
                r_state <= ST_RDATA;
                r_shift <= r_regs[r_ptr];
                r_oe    <= ~r_regs[r_ptr][7];
              end else begin
                r_state <= ST_REG;
                r_oe    <= 1'b0;
              end
            end
          end
          ST_ACK_REG: begin
            if (w_scl_fall) begin
              r_state <= ST_WDATA;
              r_oe    <= 1'b0;
            end
          end
          ST_ACK_DATA: begin
            if (w_scl_fall) begin
              r_state <= ST_WAIT_STOP;
              r_oe    <= 1'b0;
            end
          end
          ST_RDATA: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_state   <= ST_RD_NA;
                r_bit_cnt <= 4'd0;
                r_oe      <= 1'b0;
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_oe    <= ~r_shift[6];
              end
            end
          end
          ST_RD_NA: begin
            if (w_scl_fall) r_state <= ST_WAIT_STOP;
          end
          default: ;
        endcase
      end
    end
  end

  assign SIOD_oe   = r_oe;
  assign wr_valid  = r_wr_valid;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a task-driven SCCB master on an open-drain SIOD line,
// a register-file/pointer reference model and a write scoreboard.
module tb_sccb_target;
  import sccb_pkg::*;

  logic        clk;
  logic        reset;
  logic        sioc_m;
  logic        sda_m;
  logic        siod;
  logic        siod_oe;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  sccb_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int q_clk   = 62;  // quarter SCL period in 25 MHz clocks (about 100 kHz)
  int oe_cycles = 0;
  int wr_long   = 0;
  logic wr_prev = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [7:0]  model_regs [256];
  logic [7:0]  model_ptr;

  assign siod = sda_m & ~siod_oe;

  sccb_target #(.DEV_ADDR(8'h42), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SIOC(sioc_m), .SIOD(siod),
    .SIOD_oe(siod_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #20ns clk = ~clk;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (wr_valid) obs_q.push_back({wr_addr, wr_data});
    if (wr_valid && wr_prev) wr_long++;
    wr_prev = wr_valid;
    if (siod_oe) oe_cycles++;
  end

  // ---------------- master driver tasks ----------------
  task automatic quarter();
    repeat (q_clk) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; quarter();
    sioc_m = 1'b1; quarter();
    sda_m = 1'b0; quarter();
    sioc_m = 1'b0; quarter();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; quarter();
    sioc_m = 1'b1; quarter();
    sda_m = 1'b1; quarter();
    quarter();
  endtask

  task automatic clock_bit(input logic b, output logic line);
    sda_m = b; quarter();
    sioc_m = 1'b1; quarter();
    line = siod; quarter();
    sioc_m = 1'b0; quarter();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], l);
    clock_bit(1'b1, l);
    ack = ~l;
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, l);
      d[i] = l;
    end
    clock_bit(1'b1, l);  // master NA
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    model_ptr = 8'h00;
  endtask

  task automatic model_full_write(input logic [7:0] ra, input logic [7:0] da);
    model_ptr = ra;
    model_regs[ra] = da;
    exp_q.push_back({ra, da});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; sioc_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
    n_tests++; if (siod_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", siod_oe); end
    n_tests++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
    n_tests++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_tests++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_write_basic();
    logic a0, a1, a2, busy_mid;
    logic bad;
    exp_q.delete(); obs_q.delete(); wr_long = 0;
    bus_start();
    send_byte(8'h42, a0); send_byte(8'h12, a1); send_byte(8'h80, a2);
    busy_mid = busy;
    bus_stop();
    model_full_write(8'h12, 8'h80);
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL basic_acks: got %b want 111", {a0, a1, a2}); end
    n_tests++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b want 1", busy_mid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_stop: got %b want 0", busy); end
    n_tests++; if (wr_long !== 0) begin n_fail++; $display("FAIL basic_pulse_width: got %0d long pulses want 0", wr_long); end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL basic_writes: got %p want %p", obs_q, exp_q); end
  endtask

  task automatic test_wrong_dev();
    logic a0, a1, a2;
    exp_q.delete(); obs_q.delete(); oe_cycles = 0;
    bus_start();
    send_byte(8'h60, a0); send_byte(8'h12, a1); send_byte(8'h55, a2);
    bus_stop();
    n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL wrongdev_ack: got %b want 0", a0); end
    n_tests++; if (oe_cycles !== 0) begin n_fail++; $display("FAIL wrongdev_oe: got %0d driven cycles want 0", oe_cycles); end
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL wrongdev_writes: got %0d want 0", obs_q.size()); end
  endtask

  task automatic test_two_phase_read();
    logic a0, a1, a2, r0, r1;
    logic [7:0] rd;
    logic bad;
    exp_q.delete(); obs_q.delete();
    bus_start(); send_byte(8'h42, a0); send_byte(8'h3A, a1); send_byte(8'hC3, a2); bus_stop();
    model_full_write(8'h3A, 8'hC3);
    model_ptr = 8'h01;  // deliberately stale; the 2-phase write below must fix it
    bus_start(); send_byte(8'h42, r0); send_byte(8'h3A, r1); bus_stop();
    model_ptr = 8'h3A;
    bus_start(); send_byte(8'h43, a0); recv_byte(rd); bus_stop();
    n_tests++; if ({a1, a2, r0, r1} !== 4'b1111) begin n_fail++; $display("FAIL twophase_acks: got %b want 1111", {a1, a2, r0, r1}); end
    n_tests++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL read_dev_ack: got %b want 1", a0); end
    n_tests++; if (rd !== model_regs[model_ptr]) begin n_fail++; $display("FAIL read_3A: got %h want %h", rd, model_regs[model_ptr]); end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL twophase_writes: got %p want %p", obs_q, exp_q); end
  endtask

  task automatic test_partial_byte();
    logic a0, a1, a2, l;
    logic bad;
    exp_q.delete(); obs_q.delete();
    bus_start(); send_byte(8'h42, a0);
    for (int i = 0; i < 4; i++) clock_bit(i[0], l);
    bus_stop();
    n_tests++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL partial_no_write: got %0d want 0", obs_q.size()); end
    bus_start(); send_byte(8'h42, a0); send_byte(8'h01, a1); send_byte(8'h02, a2); bus_stop();
    model_full_write(8'h01, 8'h02);
    n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL partial_next_acks: got %b want 111", {a0, a1, a2}); end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL partial_next_write: got %p want %p", obs_q, exp_q); end
  endtask

  task automatic test_reset_during_ack();
    logic a0, l, oe_before;
    logic [7:0] rd;
    logic [7:0] b;
    b = 8'h34;
    bus_start(); send_byte(8'h42, a0);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], l);
    oe_before = siod_oe;
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (oe_before !== 1'b1) begin n_fail++; $display("FAIL rstack_oe_before: got %b want 1", oe_before); end
    n_tests++; if (siod_oe !== 1'b0) begin n_fail++; $display("FAIL rstack_oe_release: got %b want 0", siod_oe); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstack_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    sda_m = 1'b1; quarter();
    bus_stop();
    bus_start(); send_byte(8'h43, a0); recv_byte(rd); bus_stop();
    n_tests++; if (rd !== model_regs[model_ptr]) begin n_fail++; $display("FAIL rstack_read_ptr: got %h want %h", rd, model_regs[model_ptr]); end
    bus_start(); send_byte(8'h42, a0); send_byte(8'h01, a0); bus_stop();
    model_ptr = 8'h01;
    bus_start(); send_byte(8'h43, a0); recv_byte(rd); bus_stop();
    n_tests++; if (rd !== model_regs[model_ptr]) begin n_fail++; $display("FAIL rstack_regfile_cleared: got %h want %h", rd, model_regs[model_ptr]); end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2, a3, busy_rs;
    logic [7:0] rd;
    bus_start(); send_byte(8'h42, a0); send_byte(8'h20, a1); send_byte(8'h5A, a2); bus_stop();
    model_full_write(8'h20, 8'h5A);
    bus_start(); send_byte(8'h42, a0); send_byte(8'h20, a1);
    bus_start();
    busy_rs = busy;
    send_byte(8'h43, a3); recv_byte(rd); bus_stop();
    model_ptr = 8'h20;
    n_tests++; if ({a0, a1, a3} !== 3'b111) begin n_fail++; $display("FAIL rs_acks: got %b want 111", {a0, a1, a3}); end
    n_tests++; if (busy_rs !== 1'b1) begin n_fail++; $display("FAIL rs_busy: got %b want 1", busy_rs); end
    n_tests++; if (rd !== model_regs[model_ptr]) begin n_fail++; $display("FAIL rs_read: got %h want %h", rd, model_regs[model_ptr]); end
  endtask

  task automatic test_random();
    logic a0, a1, a2, good, bad;
    logic [7:0] dev, ra, da, rd, want;
    int op;
    exp_q.delete(); obs_q.delete();
    for (int it = 0; it < 6; it++) begin
      op   = $urandom_range(0, 2);
      ra   = 8'($urandom_range(0, 255));
      da   = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      dev  = 8'h42;
      if (!good) begin
        do dev = 8'($urandom_range(0, 255)); while (dev[7:1] == 7'h21);
      end
      bus_start();
      if (op == 2) begin
        send_byte(dev | 8'h01, a0); recv_byte(rd); bus_stop();
        want = good ? model_regs[model_ptr] : 8'hFF;
        n_tests++; if (rd !== want) begin n_fail++; $display("FAIL rand_read[%0d]: got %h want %h", it, rd, want); end
      end else begin
        send_byte(dev, a0); send_byte(ra, a1);
        if (op == 0) send_byte(da, a2);
        bus_stop();
        if (good && op == 0) model_full_write(ra, da);
        else if (good) model_ptr = ra;
      end
      n_tests++; if (a0 !== good) begin n_fail++; $display("FAIL rand_dev_ack[%0d]: got %b want %b", it, a0, good); end
    end
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL rand_writes: got %p want %p", obs_q, exp_q); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; sioc_m = 1'b1; sda_m = 1'b1;
    test_reset();
    test_write_basic();
    test_wrong_dev();
    test_two_phase_read();
    q_clk = 16;  // remaining scenarios at a faster SCL to keep the run short
    test_partial_byte();
    test_reset_during_ack();
    test_repeated_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
